// File: rtl/integrator_dump.sv
// Integrate-and-dump: saturating signed accumulation over DUMP_LEN samples,
// result and sticky clamp flag delivered through a one-entry valid/ready register.
module integrator_dump #(
  parameter int WIDTH    = 10,
  parameter int DUMP_LEN = 8
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clear,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DUMP_LEN - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             win_sat_q, win_sat_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum_w;
  logic             clamped;
  logic [WIDTH-1:0] sat_val;
  logic             last;
  logic             fire;

  always_comb begin
    sum_w   = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
    clamped = sum_w[WIDTH] ^ sum_w[WIDTH-1];
    // Overflow only occurs with like-signed operands, so acc sign picks the rail
    if (clamped) sat_val = (acc_q[WIDTH-1] & in_data[WIDTH-1]) ? SAT_MIN : SAT_MAX;
    else         sat_val = sum_w[WIDTH-1:0];
  end

  always_comb begin
    last     = (cnt_q == CNT_LAST);
    in_ready = !clear && !(last && out_valid_q && !out_ready);
    fire     = in_valid && in_ready;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_sat_d   = win_sat_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      win_sat_d = 1'b0;
    end else if (fire) begin
      if (last) begin
        out_data_d  = sat_val;
        out_sat_d   = win_sat_q | clamped;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        win_sat_d   = 1'b0;
      end else begin
        acc_d     = sat_val;
        cnt_d     = cnt_q + CW'(1);
        win_sat_d = win_sat_q | clamped;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      win_sat_q   <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      win_sat_q   <= win_sat_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_integrator_dump.sv
// Bench for integrator_dump at WIDTH=10, DUMP_LEN=4: vector table, corner
// sequences and a randomized run against a window-level saturating model.
module tb_integrator_dump;

  localparam int W = 10;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         clear = 1'b0;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  integrator_dump #(.WIDTH(W), .DUMP_LEN(N)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .clear          (clear),
    .out_data       (out_data),
    .out_sat        (out_sat),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr; logic vld; int data; logic ordy;
    logic rdy; logic ov;  int od;   logic os;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // One cycle: drive after negedge, capture in_ready before the edge, settle after it
  task automatic step(input logic c, input logic v, input int d, input logic r,
                      output logic rdy);
    @(negedge clk);
    clear = c; in_valid = v; in_data = W'(d); out_ready = r;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input int od, input logic os);
    chk({tag, "_out_valid"}, int'(out_valid), int'(ov));
    chk({tag, "_out_data"},  sdata(), od);
    chk({tag, "_out_sat"},   int'(out_sat), int'(os));
  endtask

  function automatic int clamp(input int s);
    if (s > 511)  return 511;
    if (s < -512) return -512;
    return s;
  endfunction

  initial begin
    logic rdy;
    int   nacc;
    int   win[$];
    int   m_out, accepted, dumps, drains, r, d, s;
    logic m_sat, m_pend, m_rdy, c, v, o;

    repeat (2) @(posedge clk);
    #1 check_out("reset", 1'b0, 0, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1 chk("reset_in_ready", int'(in_ready), 1);

    // Basic sums, clamping, sticky flag per window, idle, clear, gaps
    tbl.push_back('{0,1,10,1,  1,0,0,0});
    tbl.push_back('{0,1,20,1,  1,0,0,0});
    tbl.push_back('{0,1,30,1,  1,0,0,0});
    tbl.push_back('{0,1,40,1,  1,1,100,0});
    tbl.push_back('{0,1,300,1, 1,0,100,0});
    tbl.push_back('{0,1,300,1, 1,0,100,0});
    tbl.push_back('{0,1,-100,1,1,0,100,0});
    tbl.push_back('{0,1,0,1,   1,1,411,1});
    for (int i = 0; i < 3; i++) tbl.push_back('{0,1,-512,1,1,0,411,1});
    tbl.push_back('{0,1,-512,1,1,1,-512,1});
    for (int i = 0; i < 3; i++) tbl.push_back('{0,1,1,1,1,0,-512,1});
    tbl.push_back('{0,1,1,1,   1,1,4,0});
    tbl.push_back('{0,0,0,1,   1,0,4,0});
    tbl.push_back('{0,1,5,1,   1,0,4,0});
    tbl.push_back('{0,1,5,1,   1,0,4,0});
    tbl.push_back('{1,1,7,1,   0,0,4,0});
    for (int i = 0; i < 3; i++) tbl.push_back('{0,1,2,1,1,0,4,0});
    tbl.push_back('{0,1,2,1,   1,1,8,0});
    tbl.push_back('{0,1,3,1,   1,0,8,0});
    tbl.push_back('{0,0,0,1,   1,0,8,0});
    tbl.push_back('{0,1,3,1,   1,0,8,0});
    tbl.push_back('{0,1,3,1,   1,0,8,0});
    tbl.push_back('{0,1,3,1,   1,1,12,0});

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].vld, tbl[i].data, tbl[i].ordy, rdy);
      chk($sformatf("vec%0d_in_ready", i), int'(rdy), int'(tbl[i].rdy));
      check_out($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].os);
    end

    // Back-pressure: full output, three non-dumping samples accepted, then stall
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1, 1'b0, rdy);
      if (rdy) nacc++;
    end
    chk("bp_accepted", nacc, 3);
    chk("bp_stalled_ready", int'(rdy), 0);
    check_out("bp_hold", 1'b1, 12, 1'b0);
    step(1'b0, 1'b1, 1, 1'b1, rdy);
    chk("bp_release_ready", int'(rdy), 1);
    check_out("bp_drain_dump", 1'b1, 4, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, rdy);
    check_out("bp_drained", 1'b0, 4, 1'b0);

    // Reset discards a pending result and a partial window
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3, 1'b0, rdy);
    check_out("rst_pending", 1'b1, 12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9, 1'b0, rdy);
    chk("rst_partial_ready", int'(rdy), 1);
    @(negedge clk) begin rst = 1'b1; in_valid = 1'b0; end
    @(posedge clk) #1;
    check_out("rst_mid", 1'b0, 0, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_mid_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2, 1'b1, rdy);
    check_out("rst_after", 1'b1, 8, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, rdy);

    // Randomized run; model holds accepted samples of the open window and
    // folds them with clamped integer arithmetic when the window fills
    m_pend = 1'b0; m_out = 8; m_sat = 1'b0;
    accepted = 0; dumps = 0; drains = 0;
    for (int cyc = 0; cyc < 40000 && accepted < 10000; cyc++) begin
      r = int'($urandom_range(0, 1023));
      d = (r >= 512) ? r - 1024 : r;
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 4) < 3);
      @(negedge clk);
      clear = c; in_valid = v; in_data = W'(d); out_ready = o;
      #1;
      m_rdy = !c && !(win.size() == N-1 && m_pend && !o);
      chk("rand_in_ready", int'(in_ready), int'(m_rdy));
      chk("rand_out_valid", int'(out_valid), int'(m_pend));
      if (m_pend) begin
        chk("rand_out_data", sdata(), m_out);
        chk("rand_out_sat", int'(out_sat), int'(m_sat));
      end
      if (m_pend && o) begin
        m_pend = 1'b0;
        drains++;
      end
      if (c) win.delete();
      else if (v && m_rdy) begin
        accepted++;
        win.push_back(d);
        if (win.size() == N) begin
          m_out = 0; m_sat = 1'b0;
          foreach (win[k]) begin
            s = m_out + win[k];
            if (clamp(s) != s) m_sat = 1'b1;
            m_out = clamp(s);
          end
          win.delete();
          m_pend = 1'b1;
          dumps++;
        end
      end
      @(posedge clk);
    end
    chk("rand_progress", int'(accepted >= 10000), 1);
    chk("rand_conservation", dumps, drains + int'(m_pend));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integrator_dump.md
# integrator_dump

Integrate-and-dump stage built around the saturating signed adder of the Integrator path. It accumulates a stream of signed samples with per-step saturation over a fixed window of `DUMP_LEN` samples. At the end of each window it emits the window sum, plus a flag recording whether any step clamped, through a one-entry valid/ready output register. It sits directly downstream of the sample source and feeds the decimated Integrator output.

## Interface
- `WIDTH`, default 10: sample, accumulator and result width, two's-complement signed.
- `DUMP_LEN`, default 8: samples per window; legal range 2..256.

Ports:
- `system1000`  in  1  clock; all state updates on the rising edge.
- `system1000_rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  WIDTH  signed sample.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle; a transfer occurs when `in_valid` and `in_ready` are both high.
- `clear`  in  1  synchronous window abort.
- `out_data`  out  WIDTH  signed window result.
- `out_sat`  out  1  at least one accumulation step in this window clamped.
- `out_valid`  out  1  output register holds an unconsumed result.
- `out_ready`  in  1  consumer takes the result when `out_valid` and `out_ready` are both high.

## Operation
- State:
  - `acc`, WIDTH signed accumulator.
  - `cnt`, counter of samples accepted in the current window, range 0..DUMP_LEN-1.
  - `win_sat`, sticky flag for the current window.
  - Output register holding `out_data`, `out_sat` and `out_valid`.
- Saturating add `sat(a,b)`:
  - Form a WIDTH+1-bit signed sum.
  - If the sum's bit WIDTH equals its bit WIDTH-1, the result is the low WIDTH bits.
  - Otherwise the step has overflowed. If both operands are negative, the result is the minimum value (-512 at WIDTH=10); otherwise it is the maximum value (+511).
  - The `clamped` signal is the overflow condition.
- Transfer with `cnt < DUMP_LEN-1`:
  - `acc <= sat(acc, in_data)`.
  - `cnt <= cnt+1`.
  - `win_sat <= win_sat | clamped`.
- Transfer with `cnt == DUMP_LEN-1` (dump):
  - `out_data <= sat(acc, in_data)`.
  - `out_sat <= win_sat | clamped`.
  - `out_valid <= 1`.
  - `acc`, `cnt` and `win_sat` return to 0.
- Intermediate clamped values carry forward. Accumulation continues from the clamped value; there is no unclamping.
- Output drain: when `out_valid && out_ready` and no dump occurs this cycle, `out_valid <= 0`. `out_data` and `out_sat` hold their last values.
- Simultaneous drain and dump: the new result is loaded and `out_valid` stays 1.
- `in_ready = !clear && !(cnt == DUMP_LEN-1 && out_valid && !out_ready)`.
  - The block stalls only when the next sample would dump into a full register that is not draining this cycle.
  - Non-dumping samples are accepted even while the output is full.
- `clear`:
  - Sets `acc`, `cnt` and `win_sat` to 0.
  - Forces `in_ready` low, so no sample is consumed in the `clear` cycle.
  - Does not touch the output register, and `out_ready` draining proceeds normally.
- Reset: `acc=0`, `cnt=0`, `win_sat=0`, `out_data=0`, `out_sat=0`, `out_valid=0`. `in_ready` is 1 from the first cycle after reset, provided `clear` is low.
- Reset mid-window discards the partial sum. Reset with `out_valid=1` discards the pending result.

## Timing
- One sample per cycle maximum; no bubbles while unstalled.
- Latency: `out_valid` rises on the edge that accepts the `DUMP_LEN`th sample and is visible the next cycle.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `cnt` and `clear`. `out_valid`, `out_data` and `out_sat` are registered.
- Throughput: with `out_ready` held high, one result every `DUMP_LEN` accepted samples, back-to-back windows with no gap.
- `in_valid` low leaves all state unchanged; gaps inside a window are allowed.

## Test plan
1. `DUMP_LEN=4`; feed 10, 20, 30, 40 with `out_ready=1` -> one cycle after 40 is accepted, `out_valid=1`, `out_data=100`, `out_sat=0`; `out_valid=0` the following cycle.
2. Feed 300, 300, -100, 0 -> the step 300+300 clamps to 511; `out_data=411`, `out_sat=1`. Feed -512 four times -> `out_data=-512`, `out_sat=1`. Next window 1, 1, 1, 1 -> `out_data=4`, `out_sat=0`, confirming the sticky flag clears per window.
3. Back-pressure: after one dump hold `out_ready=0` and feed 8 samples of 1 -> three are accepted. `in_ready=0` with `cnt=3` until `out_ready` goes high. In that cycle the first result drains and the 4th sample dumps in the same cycle; `out_valid` stays 1 and `out_data=4`.
4. Clear: feed 5, 5, assert `clear` with `in_valid=1` and `in_data=7` -> `in_ready=0`, the 7 is not consumed. Then feed 1, 1, 1, 1 -> `out_data=4`, no contribution from the earlier 5s.
5. Reset: feed 9, 9, 9, then pulse `system1000_rst` -> next cycle `out_valid=0`, `out_data=0`, `in_ready=1`. Four samples of 2 -> `out_data=8`.
6. Random signed stimulus over 10k samples, with random `in_valid`, `out_ready` and occasional `clear` -> every result matches a reference saturating model; no result is lost or duplicated, and no sample is accepted while `in_ready=0`.
